// File: rtl/operand_loader_pkg.sv
// Shared constants for the operand entry block: state encoding and nibble width.
package operand_loader_pkg;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        WRITE = 2'd2
    } state_t;
endpackage

// File: rtl/operand_loader_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one button level.
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic ev_o
);
    // sh[0..1] synchronize, sh[2] holds the previous synchronized level
    logic [2:0] sh;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sh <= '0;
        else       sh <= {sh[1:0], btn_i};
    end

    assign ev_o = sh[1] & ~sh[2];
endmodule

// File: rtl/operand_loader.sv
// Nibble-serial operand entry feeding two DEPTHxN operand memories with async read ports.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    localparam int CW   = $clog2(N / NIB_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             push_i,
    input  logic             commit_i,
    input  logic             clear_i,
    input  logic             sel_mem_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [AW-1:0]    addra_i,
    input  logic [AW-1:0]    addrb_i,
    output logic [N-1:0]     opea_o,
    output logic [N-1:0]     opeb_o,
    output logic [N-1:0]     shadow_o,
    output logic [CW-1:0]    count_o,
    output logic [1:0]       state_o,
    output logic             wr_done_o
);
    localparam logic [CW-1:0] CNT_MAX = CW'(N / NIB_W);

    logic [2:0]    ev;
    logic          push_ev, commit_ev, clear_ev;
    state_t        state;
    logic          tgt_sel;
    logic [AW-1:0] tgt_addr;
    logic [N-1:0]  mem_a [DEPTH];
    logic [N-1:0]  mem_b [DEPTH];

    edge_sync u_sync [2:0] (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i ({clear_i, commit_i, push_i}),
        .ev_o  (ev)
    );

    assign {clear_ev, commit_ev, push_ev} = ev;

    // Priority is clear > commit > push in every state; a lower event is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            shadow_o  <= '0;
            count_o   <= '0;
            wr_done_o <= 1'b0;
            tgt_sel   <= 1'b0;
            tgt_addr  <= '0;
        end else begin
            wr_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear_ev && !commit_ev && push_ev) begin
                        shadow_o <= N'(nibble_i);
                        count_o  <= CW'(1);
                        state    <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (clear_ev) begin
                        shadow_o <= '0;
                        count_o  <= '0;
                        state    <= IDLE;
                    end else if (commit_ev) begin
                        tgt_sel   <= sel_mem_i;
                        tgt_addr  <= waddr_i;
                        wr_done_o <= 1'b1;
                        state     <= WRITE;
                    end else if (push_ev) begin
                        shadow_o <= {shadow_o[N-NIB_W-1:0], nibble_i};
                        if (count_o != CNT_MAX) count_o <= count_o + CW'(1);
                    end
                end
                WRITE: begin
                    count_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (state == WRITE) begin
            if (tgt_sel) mem_b[tgt_addr] <= shadow_o;
            else         mem_a[tgt_addr] <= shadow_o;
        end
    end

    assign opea_o = mem_a[addra_i];
    assign opeb_o = mem_b[addrb_i];
endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
module tb_operand_loader;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  nibble_i;
    logic        push_i, commit_i, clear_i, sel_mem_i;
    logic [2:0]  waddr_i, addra_i, addrb_i;
    logic [31:0] opea_o, opeb_o, shadow_o;
    logic [3:0]  count_o;
    logic [1:0]  state_o;
    logic        wr_done_o;

    int total = 0;
    int bad   = 0;

    operand_loader dut (
        .clk_i(clk_i), .rst_i(rst_i), .nibble_i(nibble_i), .push_i(push_i),
        .commit_i(commit_i), .clear_i(clear_i), .sel_mem_i(sel_mem_i),
        .waddr_i(waddr_i), .addra_i(addra_i), .addrb_i(addrb_i),
        .opea_o(opea_o), .opeb_o(opeb_o), .shadow_o(shadow_o),
        .count_o(count_o), .state_o(state_o), .wr_done_o(wr_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic press(input logic [3:0] n);
        nibble_i = n;
        push_i = 1'b1;
        repeat (2) @(negedge clk_i);
        push_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_commit(input logic s, input logic [2:0] a, output int pulses);
        sel_mem_i = s;
        waddr_i = a;
        commit_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (wr_done_o) pulses++;
            if (i == 1) commit_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int a = 0; a < 8; a++) begin
            addra_i = 3'(a);
            addrb_i = 3'(a);
            #1;
            total++;
            if (opea_o !== 32'h0 || opeb_o !== 32'h0) begin
                bad++;
                $display("FAIL reset_mem addr=%0d got a=%h b=%h want 0", a, opea_o, opeb_o);
            end
        end
        total++;
        if (shadow_o !== 32'h0 || count_o !== 4'd0 || state_o !== 2'd0 || wr_done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs got shadow=%h count=%0d state=%0d wr=%b want 0", shadow_o, count_o, state_o, wr_done_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_commit_a;
        int p;
        for (int i = 1; i <= 8; i++) press(4'(i));
        total++;
        if (shadow_o !== 32'h12345678 || count_o !== 4'd8 || state_o !== 2'd1) begin
            bad++;
            $display("FAIL entry8 got shadow=%h count=%0d state=%0d want 12345678/8/1", shadow_o, count_o, state_o);
        end
        do_commit(1'b0, 3'd3, p);
        total++;
        if (p !== 1) begin
            bad++;
            $display("FAIL commit_a_pulse got %0d want 1", p);
        end
        addra_i = 3'd3;
        addrb_i = 3'd3;
        #1;
        total++;
        if (opea_o !== 32'h12345678 || opeb_o !== 32'h0) begin
            bad++;
            $display("FAIL commit_a_mem got a=%h b=%h want 12345678/0", opea_o, opeb_o);
        end
        total++;
        if (shadow_o !== 32'h12345678 || count_o !== 4'd0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL after_write got shadow=%h count=%0d state=%0d want 12345678/0/0", shadow_o, count_o, state_o);
        end
    endtask

    task automatic test_overflow;
        int p;
        for (int i = 1; i <= 9; i++) press(4'(i));
        total++;
        if (shadow_o !== 32'h23456789 || count_o !== 4'd8) begin
            bad++;
            $display("FAIL overflow got shadow=%h count=%0d want 23456789/8", shadow_o, count_o);
        end
        do_commit(1'b1, 3'd7, p);
        addrb_i = 3'd7;
        addra_i = 3'd7;
        #1;
        total++;
        if (opeb_o !== 32'h23456789 || opea_o !== 32'h0 || p !== 1) begin
            bad++;
            $display("FAIL commit_b got b=%h a=%h pulses=%0d want 23456789/0/1", opeb_o, opea_o, p);
        end
    endtask

    task automatic test_clear;
        int p;
        press(4'hA);
        press(4'hB);
        clear_i = 1'b1;
        repeat (2) @(negedge clk_i);
        clear_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if (shadow_o !== 32'h0 || count_o !== 4'd0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL clear got shadow=%h count=%0d state=%0d want 0/0/0", shadow_o, count_o, state_o);
        end
        do_commit(1'b0, 3'd3, p);
        addra_i = 3'd3;
        addrb_i = 3'd7;
        #1;
        total++;
        if (p !== 0 || opea_o !== 32'h12345678 || opeb_o !== 32'h23456789 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL idle_commit got pulses=%0d a=%h b=%h state=%0d want 0/12345678/23456789/0", p, opea_o, opeb_o, state_o);
        end
    endtask

    task automatic test_simultaneous;
        int p;
        press(4'h5);
        press(4'h6);
        nibble_i = 4'h7;
        push_i = 1'b1;
        clear_i = 1'b1;
        repeat (2) @(negedge clk_i);
        push_i = 1'b0;
        clear_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if (shadow_o !== 32'h0 || count_o !== 4'd0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL push_clear got shadow=%h count=%0d state=%0d want 0/0/0", shadow_o, count_o, state_o);
        end
        press(4'hC);
        press(4'hD);
        nibble_i = 4'hE;
        push_i = 1'b1;
        do_commit(1'b0, 3'd5, p);
        push_i = 1'b0;
        repeat (2) @(negedge clk_i);
        addra_i = 3'd5;
        #1;
        total++;
        if (p !== 1 || opea_o !== 32'h000000CD || shadow_o !== 32'h000000CD || state_o !== 2'd0) begin
            bad++;
            $display("FAIL commit_push got pulses=%0d a=%h shadow=%h state=%0d want 1/cd/cd/0", p, opea_o, shadow_o, state_o);
        end
    endtask

    task automatic test_held;
        nibble_i = 4'hF;
        push_i = 1'b1;
        repeat (20) @(negedge clk_i);
        total++;
        if (shadow_o !== 32'h0000000F || count_o !== 4'd1 || state_o !== 2'd1) begin
            bad++;
            $display("FAIL held_push got shadow=%h count=%0d state=%0d want f/1/1", shadow_o, count_o, state_o);
        end
        push_i = 1'b0;
        repeat (4) @(negedge clk_i);
        total++;
        if (shadow_o !== 32'h0000000F || count_o !== 4'd1) begin
            bad++;
            $display("FAIL held_release got shadow=%h count=%0d want f/1", shadow_o, count_o);
        end
    endtask

    task automatic test_reset_mid_write;
        int budget;
        sel_mem_i = 1'b1;
        waddr_i = 3'd2;
        addrb_i = 3'd2;
        addra_i = 3'd3;
        commit_i = 1'b1;
        budget = 0;
        while (state_o !== 2'd2 && budget < 10) begin
            @(negedge clk_i);
            budget++;
        end
        total++;
        if (state_o !== 2'd2 || wr_done_o !== 1'b1 || opeb_o !== 32'h0) begin
            bad++;
            $display("FAIL write_cycle got state=%0d wr=%b b=%h want 2/1/0", state_o, wr_done_o, opeb_o);
        end
        #1 rst_i = 1'b1;
        #1;
        total++;
        if (opea_o !== 32'h0 || opeb_o !== 32'h0 || shadow_o !== 32'h0 || count_o !== 4'd0 ||
            state_o !== 2'd0 || wr_done_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_write_reset got a=%h b=%h shadow=%h count=%0d state=%0d wr=%b want all 0",
                     opea_o, opeb_o, shadow_o, count_o, state_o, wr_done_o);
        end
        commit_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        total++;
        if (opeb_o !== 32'h0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL lost_write got b=%h state=%0d want 0/0", opeb_o, state_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        nibble_i = '0;
        push_i = 1'b0;
        commit_i = 1'b0;
        clear_i = 1'b0;
        sel_mem_i = 1'b0;
        waddr_i = '0;
        addra_i = '0;
        addrb_i = '0;
        test_reset();
        test_commit_a();
        test_overflow();
        test_clear();
        test_simultaneous();
        test_held();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
